// File: rtl/quad_dec.sv
// Quadrature decoder: synchronises and filters the A/B/home/index pins, then
// decodes x4 quadrature into a wrapping position count. It also captures the
// position on index, flags home/index/illegal transitions and toggles led per index.
module quad_dec #(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned FILT_LEN  = 4,
    parameter bit          HOME_ZERO = 1'b1
) (
    input  logic             freq_clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clr,
    input  logic             pha,
    input  logic             phb,
    input  logic             home,
    input  logic             index,
    output logic [CNT_W-1:0] position,
    output logic             dir,
    output logic             step,
    output logic [CNT_W-1:0] index_pos,
    output logic             index_seen,
    output logic             home_seen,
    output logic             err,
    output logic             led
);

    // Line order in the 4-bit vectors: 0 = A, 1 = B, 2 = home, 3 = index.
    localparam int unsigned    NUM_LINES = 4;
    localparam logic [3:0]     FILT_MAX  = 4'(FILT_LEN);
    localparam logic [4:0]     WARM_CYC  = 5'(3 + FILT_LEN);
    localparam logic [CNT_W-1:0] POS_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]       w_pins;
    logic [3:0]       r_sync1, r_sync2;
    logic [3:0]       r_filt, w_filt_d;
    logic [3:0]       r_fcnt [NUM_LINES];
    logic [3:0]       w_fcnt_d [NUM_LINES];
    logic [3:0]       r_prev;
    logic [4:0]       r_warm;

    logic [1:0]       w_ab_prev, w_ab_cur;
    logic             w_fwd, w_rev, w_ill;
    logic             w_active, w_idx_rise, w_home_rise;

    logic [CNT_W-1:0] r_position, w_position_d;
    logic [CNT_W-1:0] r_index_pos, w_index_pos_d;
    logic             r_dir, w_dir_d;
    logic             r_step, w_step_d;
    logic             r_index_seen, w_index_seen_d;
    logic             r_home_seen, w_home_seen_d;
    logic             r_err, w_err_d;
    logic             r_led, w_led_d;

    assign w_pins = {index, home, phb, pha};

    // Two-stage synchroniser for every asynchronous pin.
    always_ff @(posedge freq_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_pins;
            r_sync2 <= r_sync1;
        end
    end

    // Glitch filter: a level must disagree for FILT_LEN consecutive cycles to be taken.
    always_comb begin
        w_filt_d = r_filt;
        for (int i = 0; i < NUM_LINES; i++) begin
            w_fcnt_d[i] = '0;
            if (r_sync2[i] != r_filt[i]) begin
                if (r_fcnt[i] + 4'd1 >= FILT_MAX) begin
                    w_filt_d[i] = r_sync2[i];
                end else begin
                    w_fcnt_d[i] = r_fcnt[i] + 4'd1;
                end
            end
        end
    end

    // Filter state, previous filtered levels and post-reset warm-up counter.
    always_ff @(posedge freq_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt <= '0;
            r_prev <= '0;
            r_warm <= WARM_CYC;
            for (int i = 0; i < NUM_LINES; i++) begin
                r_fcnt[i] <= '0;
            end
        end else begin
            r_filt <= w_filt_d;
            r_prev <= r_filt;  // tracks regardless of enable so re-enable is step-free
            if (r_warm != 5'd0) begin
                r_warm <= r_warm - 5'd1;
            end
            for (int i = 0; i < NUM_LINES; i++) begin
                r_fcnt[i] <= w_fcnt_d[i];
            end
        end
    end

    assign w_ab_prev   = {r_prev[0], r_prev[1]};
    assign w_ab_cur    = {r_filt[0], r_filt[1]};
    assign w_active    = enable && (r_warm == 5'd0);
    assign w_idx_rise  = r_filt[3] & ~r_prev[3];
    assign w_home_rise = r_filt[2] & ~r_prev[2];

    // Classify the {A,B} transition as forward, reverse or illegal (both lines moved).
    always_comb begin
        w_fwd = 1'b0;
        w_rev = 1'b0;
        w_ill = 1'b0;
        case ({w_ab_prev, w_ab_cur})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: w_fwd = 1'b1;
            4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: w_rev = 1'b1;
            4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: w_ill = 1'b1;
            default: ;
        endcase
    end

    // Next-state for counters and flags; clr wins over every same-cycle update.
    always_comb begin
        w_position_d   = r_position;
        w_index_pos_d  = r_index_pos;
        w_dir_d        = r_dir;
        w_step_d       = 1'b0;
        w_index_seen_d = r_index_seen;
        w_home_seen_d  = r_home_seen;
        w_err_d        = r_err;
        w_led_d        = r_led;
        if (clr) begin
            w_position_d   = '0;
            w_index_pos_d  = '0;
            w_index_seen_d = 1'b0;
            w_home_seen_d  = 1'b0;
            w_err_d        = 1'b0;
        end else if (w_active) begin
            if (w_fwd) begin
                w_position_d = r_position + POS_ONE;
                w_dir_d      = 1'b1;
                w_step_d     = 1'b1;
            end else if (w_rev) begin
                w_position_d = r_position - POS_ONE;
                w_dir_d      = 1'b0;
                w_step_d     = 1'b1;
            end
            if (w_ill) begin
                w_err_d = 1'b1;
            end
            if (w_home_rise) begin
                w_home_seen_d = 1'b1;
                if (HOME_ZERO) begin
                    w_position_d = '0;
                end
            end
            // Index captures the position as it will be after this cycle's update.
            if (w_idx_rise) begin
                w_index_pos_d  = w_position_d;
                w_index_seen_d = 1'b1;
                w_led_d        = ~r_led;
            end
        end
    end

    // Output registers.
    always_ff @(posedge freq_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_position   <= '0;
            r_index_pos  <= '0;
            r_dir        <= 1'b0;
            r_step       <= 1'b0;
            r_index_seen <= 1'b0;
            r_home_seen  <= 1'b0;
            r_err        <= 1'b0;
            r_led        <= 1'b0;
        end else begin
            r_position   <= w_position_d;
            r_index_pos  <= w_index_pos_d;
            r_dir        <= w_dir_d;
            r_step       <= w_step_d;
            r_index_seen <= w_index_seen_d;
            r_home_seen  <= w_home_seen_d;
            r_err        <= w_err_d;
            r_led        <= w_led_d;
        end
    end

    assign position   = r_position;
    assign index_pos  = r_index_pos;
    assign dir        = r_dir;
    assign step       = r_step;
    assign index_seen = r_index_seen;
    assign home_seen  = r_home_seen;
    assign err        = r_err;
    assign led        = r_led;

endmodule

// File: tb/tb_quad_dec.sv
// Directed bench for quad_dec (CNT_W=16, FILT_LEN=4, HOME_ZERO=1).
module tb_quad_dec;

    logic        freq_clk = 1'b0;
    logic        rst_n, enable, clr, pha, phb, home, index;
    logic [15:0] position, index_pos;
    logic        dir, step, index_seen, home_seen, err, led;

    int n_checks = 0;
    int n_errors = 0;
    int step_cnt = 0;
    int base     = 0;
    int idx      = 2;
    logic [1:0] fwd_seq [4];

    quad_dec #(
        .CNT_W     (16),
        .FILT_LEN  (4),
        .HOME_ZERO (1'b1)
    ) u_dut (
        .freq_clk   (freq_clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .clr        (clr),
        .pha        (pha),
        .phb        (phb),
        .home       (home),
        .index      (index),
        .position   (position),
        .dir        (dir),
        .step       (step),
        .index_pos  (index_pos),
        .index_seen (index_seen),
        .home_seen  (home_seen),
        .err        (err),
        .led        (led)
    );

    always #5 freq_clk = ~freq_clk;

    // Count step pulses just after each rising edge.
    always @(posedge freq_clk) begin
        #1;
        if (step) step_cnt = step_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge freq_clk);
    endtask

    task automatic drive_ab(input logic [1:0] ab);
        pha = ab[1];
        phb = ab[0];
        wait_cyc(10);
    endtask

    task automatic fwd_step();
        idx = (idx + 1) % 4;
        drive_ab(fwd_seq[idx]);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        wait_cyc(1);
        clr = 1'b0;
        wait_cyc(1);
    endtask

    initial begin
        fwd_seq[0] = 2'b00;
        fwd_seq[1] = 2'b10;
        fwd_seq[2] = 2'b11;
        fwd_seq[3] = 2'b01;
        rst_n = 1'b0; enable = 1'b1; clr = 1'b0;
        pha = 1'b1; phb = 1'b1; home = 1'b0; index = 1'b0;
        wait_cyc(3);
        check("rst_pos",  32'(position),   32'd0);
        check("rst_dir",  32'(dir),        32'd0);
        check("rst_step", 32'(step),       32'd0);
        check("rst_ipos", 32'(index_pos),  32'd0);
        check("rst_iseen",32'(index_seen), 32'd0);
        check("rst_hseen",32'(home_seen),  32'd0);
        check("rst_err",  32'(err),        32'd0);
        check("rst_led",  32'(led),        32'd0);

        // Idle pins at 11 through warm-up: no count, no error.
        rst_n = 1'b1;
        wait_cyc(20);
        check("warm_pos",   32'(position), 32'd0);
        check("warm_err",   32'(err),      32'd0);
        check("warm_steps", 32'(step_cnt), 32'd0);

        // 11 -> 01 -> 00 then clear.
        fwd_step();
        fwd_step();
        check("prep_pos", 32'(position), 32'd2);
        pulse_clr();
        check("clr_pos", 32'(position), 32'd0);

        // Three full forward cycles.
        base = step_cnt;
        repeat (12) fwd_step();
        check("t1_pos",   32'(position),        32'd12);
        check("t1_dir",   32'(dir),             32'd1);
        check("t1_steps", 32'(step_cnt - base), 32'd12);

        // Reverse step from zero wraps.
        pulse_clr();
        idx = (idx + 3) % 4;
        drive_ab(fwd_seq[idx]);
        check("t2_pos", 32'(position), 32'h0000_FFFF);
        check("t2_dir", 32'(dir),      32'd0);
        fwd_step();
        check("t2_wrap_up", 32'(position), 32'd0);

        // Short pulse on A rejected; FILT_LEN-long pulse accepted.
        base = step_cnt;
        pha = 1'b1;
        wait_cyc(3);
        pha = 1'b0;
        wait_cyc(10);
        check("t3_short_steps", 32'(step_cnt - base), 32'd0);
        check("t3_short_pos",   32'(position),        32'd0);
        pha = 1'b1;
        wait_cyc(4);
        pha = 1'b0;
        wait_cyc(3);
        check("t3_accept_pos",   32'(position),        32'd1);
        check("t3_accept_steps", 32'(step_cnt - base), 32'd1);
        wait_cyc(10);
        check("t3_back_pos", 32'(position), 32'd0);

        // Illegal transition 10 -> 01.
        fwd_step();
        base = step_cnt;
        idx = 3;
        drive_ab(fwd_seq[idx]);
        check("t4_err",   32'(err),             32'd1);
        check("t4_pos",   32'(position),        32'd1);
        check("t4_dir",   32'(dir),             32'd1);
        check("t4_steps", 32'(step_cnt - base), 32'd0);
        pulse_clr();
        check("t4_clr_err", 32'(err),      32'd0);
        check("t4_clr_pos", 32'(position), 32'd0);

        // Index capture at 25, then home zeroes.
        repeat (25) fwd_step();
        check("t5_pos", 32'(position), 32'd25);
        index = 1'b1;
        wait_cyc(10);
        index = 1'b0;
        wait_cyc(10);
        check("t5_ipos",  32'(index_pos),  32'd25);
        check("t5_iseen", 32'(index_seen), 32'd1);
        check("t5_led",   32'(led),        32'd1);
        home = 1'b1;
        wait_cyc(10);
        check("t5_home_pos", 32'(position),  32'd0);
        check("t5_hseen",    32'(home_seen), 32'd1);
        home = 1'b0;
        wait_cyc(10);

        // Disabled steps are ignored; re-enable gives no spurious step.
        base = step_cnt;
        enable = 1'b0;
        repeat (4) fwd_step();
        enable = 1'b1;
        wait_cyc(10);
        check("t6_dis_pos",   32'(position),        32'd0);
        check("t6_dis_steps", 32'(step_cnt - base), 32'd0);
        fwd_step();
        check("t6_resume_pos", 32'(position), 32'd1);

        // Asynchronous reset mid-operation.
        rst_n = 1'b0;
        #1;
        check("t6_rst_pos",   32'(position),   32'd0);
        check("t6_rst_dir",   32'(dir),        32'd0);
        check("t6_rst_ipos",  32'(index_pos),  32'd0);
        check("t6_rst_iseen", 32'(index_seen), 32'd0);
        check("t6_rst_hseen", 32'(home_seen),  32'd0);
        check("t6_rst_led",   32'(led),        32'd0);
        pha = 1'b1;
        phb = 1'b1;
        wait_cyc(3);
        base = step_cnt;
        rst_n = 1'b1;
        wait_cyc(30);
        check("t6_warm_steps", 32'(step_cnt - base), 32'd0);
        check("t6_warm_err",   32'(err),             32'd0);
        check("t6_warm_pos",   32'(position),        32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
